paddle_input_ctrl: RTL and testbench
====================================

PADDLE_INPUT_CTRL -- requirements
Module: paddle_input_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low, and the ports are named clk and reset.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the number of stable sampled cycles required to accept a button level change; legal range is 1..2^20-1.
REQ-003 Parameter MOVE_DIV, default 250000, SHALL set the clock cycles between repeated move strobes; legal range is 2..2^20-1.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  asynchronous, active-low; 0 = reset.
REQ-006 btn_left, btn_right, btn_pause, btn_reset  in  1 each  raw asynchronous push-buttons, active-high.
REQ-007 move_left, move_right  out  1 each  one-cycle move strobes for the paddle stage.
REQ-008 pause  out  1  pause level.
REQ-009 game_reset  out  1  one-cycle restart pulse.

Function
REQ-010 Each raw button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Each synchronized button SHALL have its own debouncer:
- The debouncer holds a debounced level and a 20-bit counter.
- The counter increments while the synchronized input differs from the debounced level.
- The counter clears to 0 on any cycle where they are equal.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the input value and the counter clears.
REQ-012 A debounced rising edge SHALL be detected by comparing against a registered copy of the debounced level.
REQ-013 A rising edge of debounced pause SHALL toggle pause on the next cycle.
REQ-014 A rising edge of debounced reset SHALL assert game_reset for exactly one cycle and force pause to 0 in that same cycle.
REQ-015 If the pause edge and the reset edge occur in the same cycle, the reset edge SHALL win: pause = 0 and game_reset = 1.
REQ-016 The direction FSM SHALL have states IDLE, LEFT and RIGHT, evaluated on the debounced levels of left (L) and right (R):
- L=1, R=0 -> LEFT.
- L=0, R=1 -> RIGHT.
- L=R -> IDLE.
REQ-017 The transition rules and the 20-bit rate counter SHALL behave as follows:
- On any transition into LEFT or RIGHT, including a direct LEFT<->RIGHT switch, the rate counter SHALL clear to 0.
- The matching strobe SHALL be asserted for one cycle on the cycle after the transition.
REQ-018 While in LEFT or RIGHT with pause = 0, the rate counter SHALL increment each cycle and wrap from MOVE_DIV-1 to 0; each wrap SHALL produce one matching strobe.
- Strobes therefore repeat every MOVE_DIV cycles while the button is held.
REQ-019 In IDLE, the rate counter SHALL be held at 0 and no strobe SHALL be produced.
REQ-020 While pause = 1:
- Both strobes SHALL be 0.
- The rate counter SHALL be held at 0.
- The FSM SHALL still track the buttons.
REQ-021 When pause falls to 0 with a direction held, the first strobe SHALL occur one cycle later, as on a state entry.
REQ-022 move_left and move_right SHALL never be 1 in the same cycle.
REQ-023 game_reset SHALL NOT alter the FSM or the rate counter; only pause is affected.
REQ-024 All outputs SHALL be registered.
REQ-025 Latency from a raw press, stable from first sampling edge, to the first strobe SHALL be 2 + DEBOUNCE_CYCLES + 1 clocks.

Reset
REQ-026 While reset = 0, the following SHALL all be 0 asynchronously, regardless of clk:
- synchronizers, debounced levels, edge registers and counters;
- FSM = IDLE;
- move_left, move_right, pause and game_reset.
REQ-027 Reset asserted mid-operation SHALL immediately clear pause and any pending strobe.
REQ-028 After reset deasserts, a button already held SHALL be treated as a new press: full debounce, then state entry, then strobe.

Verification (DEBOUNCE_CYCLES=4, MOVE_DIV=8)
REQ-029 Scenario: hold btn_left from edge 0 -> move_left pulses at edge 7, then at 15, 23, ...; move_right stays 0.
REQ-030 Scenario: btn_left glitches high for 3 cycles, then low -> no strobe; the debounced level never changes.
REQ-031 Scenario: hold btn_left, then add btn_right -> after debounce the FSM goes IDLE and strobes stop; release btn_left -> move_right pulses one cycle after the RIGHT entry, then every 8 cycles.
REQ-032 Scenario: two separate debounced btn_pause presses -> pause goes 1 then 0; while pause = 1 with left held, there are 0 strobes; a left strobe follows 1 cycle after pause falls.
REQ-033 Scenario: btn_pause and btn_reset pressed on the same edge with pause = 0 -> game_reset is 1 for exactly one cycle and pause stays 0; repeat with pause = 1 -> pause becomes 0.
REQ-034 Scenario: pull reset low mid-hold between strobes -> all outputs are 0 without a clock edge; release with btn_left still held -> first strobe 7 edges later.

Source files
------------

// File: rtl/paddle_input_ctrl_if.sv
// Button inputs and paddle-control outputs of paddle_input_ctrl.
// The master side drives the raw buttons. The slave side (the controller) drives the strobes and levels.
interface paddle_input_ctrl_if;
  logic btn_left;
  logic btn_right;
  logic btn_pause;
  logic btn_reset;
  logic move_left;
  logic move_right;
  logic pause;
  logic game_reset;

  modport master (
    output btn_left, btn_right, btn_pause, btn_reset,
    input  move_left, move_right, pause, game_reset
  );

  modport slave (
    input  btn_left, btn_right, btn_pause, btn_reset,
    output move_left, move_right, pause, game_reset
  );
endinterface

// File: rtl/paddle_input_ctrl.sv
// Paddle input controller: it synchronizes and debounces four push-buttons.
// It then drives rate-limited move strobes, a pause toggle and a one-cycle restart pulse.
module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MOVE_DIV        = 250000
) (
  input  logic               clk,
  input  logic               reset,
  paddle_input_ctrl_if.slave bus
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_LEFT   = 2'd1;
  localparam logic [1:0]  ST_RIGHT  = 2'd2;
  localparam logic [19:0] DEB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [19:0] MOVE_LAST = 20'(MOVE_DIV - 1);
  localparam int          B_LEFT    = 0;
  localparam int          B_RIGHT   = 1;
  localparam int          B_PAUSE   = 2;
  localparam int          B_RESET   = 3;

  logic [3:0]  raw_s;
  logic [3:0]  sync1_r;
  logic [3:0]  sync2_r;
  logic [3:0]  deb_r;
  logic [3:0]  deb_d_r;
  logic [3:0]  rise_s;
  logic [19:0] deb_cnt_r [4];
  logic [1:0]  state_r;
  logic [1:0]  state_next_s;
  logic [19:0] rate_cnt_r;
  logic [19:0] rate_cnt_next_s;
  logic        pause_r;
  logic        pause_next_s;
  logic        hold_s;
  logic        strobe_ok_s;
  logic        move_left_next_s;
  logic        move_right_next_s;
  logic        move_left_r;
  logic        move_right_r;
  logic        game_reset_r;

  function automatic logic [1:0] dir_decode(input logic l, input logic r);
    logic [1:0] d;
    case ({l, r})
      2'b10:   d = ST_LEFT;
      2'b01:   d = ST_RIGHT;
      default: d = ST_IDLE;
    endcase
    return d;
  endfunction

  assign raw_s  = {bus.btn_reset, bus.btn_pause, bus.btn_right, bus.btn_left};
  assign rise_s = deb_r & ~deb_d_r;

  // Two-flop synchronizers for the raw asynchronous buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-button debouncers; the counter runs only while input and level disagree
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_r   <= 4'b0000;
      deb_d_r <= 4'b0000;
      for (int i = 0; i < 4; i++) deb_cnt_r[i] <= 20'd0;
    end else begin
      deb_d_r <= deb_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          deb_cnt_r[i] <= 20'd0;
        end else if (deb_cnt_r[i] == DEB_LAST) begin
          deb_r[i]     <= sync2_r[i];
          deb_cnt_r[i] <= 20'd0;
        end else begin
          deb_cnt_r[i] <= deb_cnt_r[i] + 20'd1;
        end
      end
    end
  end

  // Next direction, pause level, rate counter and strobes
  always_comb begin
    state_next_s = dir_decode(deb_r[B_LEFT], deb_r[B_RIGHT]);
    if (rise_s[B_RESET]) begin
      pause_next_s = 1'b0;
    end else if (rise_s[B_PAUSE]) begin
      pause_next_s = ~pause_r;
    end else begin
      pause_next_s = pause_r;
    end
    // Either pause edge also counts as paused, so a strobe can never coincide with pause=1.
    // It also makes the first strobe after unpausing land one cycle after pause falls.
    hold_s = pause_r | pause_next_s;
    if ((state_next_s == ST_IDLE) || (state_next_s != state_r) || hold_s) begin
      rate_cnt_next_s = 20'd0;
    end else if (rate_cnt_r == MOVE_LAST) begin
      rate_cnt_next_s = 20'd0;
    end else begin
      rate_cnt_next_s = rate_cnt_r + 20'd1;
    end
    strobe_ok_s       = (state_next_s == state_r) && !hold_s && (rate_cnt_r == 20'd0);
    move_left_next_s  = strobe_ok_s && (state_r == ST_LEFT);
    move_right_next_s = strobe_ok_s && (state_r == ST_RIGHT);
  end

  // Registered FSM, rate counter and outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      rate_cnt_r   <= 20'd0;
      pause_r      <= 1'b0;
      game_reset_r <= 1'b0;
      move_left_r  <= 1'b0;
      move_right_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      rate_cnt_r   <= rate_cnt_next_s;
      pause_r      <= pause_next_s;
      game_reset_r <= rise_s[B_RESET];
      move_left_r  <= move_left_next_s;
      move_right_r <= move_right_next_s;
    end
  end

  assign bus.move_left  = move_left_r;
  assign bus.move_right = move_right_r;
  assign bus.pause      = pause_r;
  assign bus.game_reset = game_reset_r;

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Self-checking bench for paddle_input_ctrl: a mix of directed and random button stimulus.
// It checks the outputs every cycle against an event-level reference model.
module tb_paddle_input_ctrl;
  localparam int DEB = 4;
  localparam int DIV = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  paddle_input_ctrl_if bus();

  paddle_input_ctrl #(.DEBOUNCE_CYCLES(DEB), .MOVE_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // Reference model: run lengths and events rather than per-register state
  bit m_pipe1 [4];
  bit m_pipe2 [4];
  bit m_lvl   [4];
  bit m_lvl_d [4];
  int m_disagree [4];
  int m_dir;          // 0 none, 1 left, 2 right
  int m_live_run;     // consecutive edges with a held, unpaused direction
  bit m_pause, m_gr, m_ml, m_mr;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pipe1[i] = 1'b0; m_pipe2[i] = 1'b0; m_lvl[i] = 1'b0; m_lvl_d[i] = 1'b0;
      m_disagree[i] = 0;
    end
    m_dir = 0; m_live_run = 0;
    m_pause = 1'b0; m_gr = 1'b0; m_ml = 1'b0; m_mr = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] b);
    int dir_new;
    bit p_rise, r_rise, pause_new, live;
    dir_new   = (m_lvl[0] && !m_lvl[1]) ? 1 : ((!m_lvl[0] && m_lvl[1]) ? 2 : 0);
    p_rise    = m_lvl[2] && !m_lvl_d[2];
    r_rise    = m_lvl[3] && !m_lvl_d[3];
    pause_new = r_rise ? 1'b0 : (p_rise ? !m_pause : m_pause);
    live      = (dir_new != 0) && (dir_new == m_dir) && !m_pause && !pause_new;
    m_ml      = live && (dir_new == 1) && ((m_live_run % DIV) == 0);
    m_mr      = live && (dir_new == 2) && ((m_live_run % DIV) == 0);
    m_live_run = live ? m_live_run + 1 : 0;
    m_gr      = r_rise;
    m_pause   = pause_new;
    m_dir     = dir_new;
    for (int i = 0; i < 4; i++) begin
      m_lvl_d[i] = m_lvl[i];
      if (m_pipe2[i] != m_lvl[i]) begin
        m_disagree[i]++;
        if (m_disagree[i] == DEB) begin
          m_lvl[i] = m_pipe2[i];
          m_disagree[i] = 0;
        end
      end else begin
        m_disagree[i] = 0;
      end
      m_pipe2[i] = m_pipe1[i];
      m_pipe1[i] = b[i];
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %b expected %b", tag, edge_no, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("move_left",  bus.move_left,  m_ml);
    chk("move_right", bus.move_right, m_mr);
    chk("pause",      bus.pause,      m_pause);
    chk("game_reset", bus.game_reset, m_gr);
    chk("exclusive",  bus.move_left & bus.move_right, 1'b0);
  endtask

  task automatic step(input logic [3:0] b);
    bus.btn_left  = b[0];
    bus.btn_right = b[1];
    bus.btn_pause = b[2];
    bus.btn_reset = b[3];
    @(posedge clk);
    if (reset) model_edge(b);
    edge_no++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic steps(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  initial begin
    int first;
    int cnt;
    logic [3:0] rb;
    model_reset();
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_pause = 1'b0; bus.btn_reset = 1'b0;
    #2;
    check_outputs();
    steps(4'b0000, 2);
    reset = 1'b1;

    // Held left: first strobe at edge 7, then every DIV edges
    first = -1; cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(4'b0001);
      if (bus.move_left) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk_int("first_left_latency", first, 2 + DEB + 1);
    chk_int("left_strobe_count", cnt, 3);
    steps(4'b0000, 12);

    // Short glitch is rejected
    cnt = 0;
    steps(4'b0001, 3);
    for (int i = 0; i < 15; i++) begin
      step(4'b0000);
      cnt += bus.move_left;
    end
    chk_int("glitch_strobes", cnt, 0);

    // Left, then both, then right alone
    steps(4'b0001, 20);
    steps(4'b0011, 20);
    steps(4'b0010, 30);
    steps(4'b0000, 12);

    // Pause with left held: no strobes while paused
    cnt = 0;
    steps(4'b0101, 8);
    for (int i = 0; i < 25; i++) begin
      step(4'b0001);
      if (bus.pause) cnt += bus.move_left;
    end
    steps(4'b0101, 8);
    steps(4'b0001, 20);
    chk_int("strobes_while_paused", cnt, 0);
    steps(4'b0000, 12);

    // Pause and reset pressed together, first unpaused, then paused
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      step(4'b1100);
      cnt += bus.game_reset;
    end
    chk_int("game_reset_pulses", cnt, 1);
    chk("pause_after_combo", bus.pause, 1'b0);
    steps(4'b0000, 10);
    steps(4'b0100, 8);
    steps(4'b0000, 10);
    chk("pause_set", bus.pause, 1'b1);
    steps(4'b1100, 12);
    chk("pause_cleared_by_reset", bus.pause, 1'b0);
    steps(4'b0000, 10);

    // Asynchronous reset mid-hold, then re-entry with left still held
    steps(4'b0001, 11);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    steps(4'b0001, 2);
    reset = 1'b1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(4'b0001);
      if (bus.move_left && first < 0) first = i;
    end
    chk_int("post_reset_latency", first, 7);
    steps(4'b0000, 12);

    // Random segments
    for (int s = 0; s < 70; s++) begin
      rb[1:0] = 2'($urandom_range(0, 3));
      rb[2]   = ($urandom_range(0, 5) == 0);
      rb[3]   = ($urandom_range(0, 9) == 0);
      steps(rb, $urandom_range(1, 16));
    end
    steps(4'b0000, 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
